mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory stage directly downstream of the EX ALU.
- Takes the ALU result as the effective address and rs2 data as store data.
- Drives a word-wide data-memory request/ready handshake and returns aligned, extended load data to writeback.
- Holds `stall` high while an access is outstanding, so the core can tolerate variable-latency data memory.

Parameters:
- TIMEOUT_CYCLES, 255, number of REQ cycles without `dmem_ready` before aborting with a timeout fault; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  EX result valid this cycle
- mem_read  input  1  instruction is a load
- mem_write  input  1  instruction is a store
- funct3  input  3  access size and signedness
- alu_result  input  32  effective byte address
- store_data  input  32  rs2 value
- stall  output  1  hold the pipeline/PC
- done  output  1  one-cycle completion pulse
- load_data  output  32  extended load result
- fault  output  2  00 none, 01 misaligned, 10 timeout, 11 illegal funct3; valid with `done`
- dmem_req  output  1  request valid
- dmem_we  output  1  1 = write
- dmem_addr  output  32  word address, {alu_result[31:2],2'b00}
- dmem_wdata  output  32  lane-replicated store data
- dmem_be  output  4  byte enables
- dmem_ready  input  1  memory accepts/completes the request this cycle
- dmem_rdata  input  32  read word, valid when dmem_ready=1

Behaviour:
- Reset: async on rst_n low.
  - state=IDLE; all registered outputs 0, including load_data, fault and the timeout counter.
  - Reset mid-REQ drops dmem_req immediately; no done is produced.
- Accept rule: in IDLE, start=1 with (mem_read|mem_write) accepts the access. If mem_read and mem_write are both high, it is a load.
  - start in other states is ignored.
  - start with neither read nor write is a no-op.
- stall = (IDLE & start & (mem_read|mem_write)) | (state==REQ). It is combinational and is 0 in RESP.
- funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code → fault=11.
- Alignment:
  - Half accesses require addr[0]=0.
  - Word accesses require addr[1:0]=00.
  - Otherwise fault=01.
  - Illegal funct3 takes priority over misaligned.
- States:
  - IDLE → REQ when an accepted access has no fault; address, funct3, data, byte enables and direction are registered.
  - IDLE → RESP on a fault; no memory request is issued.
  - REQ: dmem_req=1, and dmem_addr/we/wdata/be are held stable.
    - dmem_ready sampled high at an edge → RESP. For a load, load_data is captured at that edge.
    - Counter reaches TIMEOUT_CYCLES with dmem_ready low → RESP with fault=10; dmem_req deasserts and load_data is unchanged.
  - RESP: done=1 for exactly one cycle, then IDLE. fault clears to 00 on the next accept.
- Latency:
  - Start at edge N → dmem_req high in cycle N+1.
  - Ready in cycle N+1 → done in cycle N+2, which is the minimum.
  - Fault path: done in cycle N+1.
- Store lanes (o = addr[1:0]):
  - SB: be = 4'b0001<<o, wdata = {4{data[7:0]}}.
  - SH: be = o[1] ? 1100 : 0011, wdata = {2{data[15:0]}}.
  - SW: be = 1111, wdata = data.
  - Loads drive be = 1111 and we = 0.
- Load extraction from dmem_rdata:
  - Select byte o or half o[1].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- load_data holds its value across stores, faults and idle cycles, and changes only on a completed load.
- dmem_ready outside REQ is ignored.

Test Plan:
- LW at 0x100, ready asserted one cycle after req, rdata=0xDEADBEEF → dmem_addr=0x100, be=1111, done two cycles after start, load_data=0xDEADBEEF, fault=00.
- LB at 0x103, rdata=0x80FF1234 → load_data=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x000080FF.
- SB at 0x201, store_data=0x000000AB → dmem_we=1, be=0010, wdata=0xABABABAB, addr=0x200. SH at 0x202, data=0x1234 → be=1100, wdata=0x12341234.
- LW at 0x102 → no dmem_req, done the next cycle with fault=01. funct3=011 load → fault=11.
- TIMEOUT_CYCLES=4, dmem_ready held low → stall high for 4 REQ cycles, then done with fault=10; load_data keeps its prior value.
- rst_n pulsed low while in REQ → dmem_req and stall drop immediately with no done. After release, a new LW completes normally; start asserted during REQ is ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage between EX and WB, drives a word-wide
// data-memory request/ready handshake and returns aligned, extended load data.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      EX result valid this cycle
//   mem_read, mem_write        load / store (both high is treated as a load)
//   funct3                     access size and signedness
//   alu_result                 effective byte address
//   store_data                 rs2 value
//   stall                      hold the pipeline while an access is pending
//   done                       one-cycle completion pulse
//   load_data                  extended load result, changes only on a completed load
//   fault                      00 none, 01 misaligned, 10 timeout, 11 illegal funct3
//   dmem_req/we/addr/wdata/be  data-memory request
//   dmem_ready, dmem_rdata     data-memory completion and read word
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state, state_nx;
    logic        accept;
    logic        legal;
    logic        misaligned;
    logic [1:0]  fault_nx;
    logic [3:0]  be_nx;
    logic [31:0] wdata_nx;
    logic        timed_out;
    logic [31:0] cnt;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        load_q;
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ext;

    // Access decode on the EX-side inputs; only meaningful while accepting.
    always_comb begin
        accept     = (state == IDLE) && start && (mem_read || mem_write);
        legal      = mem_read ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                              : (funct3 inside {3'b000, 3'b001, 3'b010});
        misaligned = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                     ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
        fault_nx   = !legal ? 2'b11 : misaligned ? 2'b01 : 2'b00;
        be_nx      = mem_read                 ? 4'b1111 :
                     (funct3[1:0] == 2'b00)   ? 4'b0001 << alu_result[1:0] :
                     (funct3[1:0] == 2'b01)   ? (alu_result[1] ? 4'b1100 : 4'b0011) :
                                                4'b1111;
        wdata_nx   = (funct3[1:0] == 2'b00) ? {4{store_data[7:0]}} :
                     (funct3[1:0] == 2'b01) ? {2{store_data[15:0]}} :
                                              store_data;
    end

    // Timeout fires on the last allowed REQ cycle; ready on that same edge wins.
    always_comb begin
        timed_out = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_CYCLES - 1);
    end

    // Lane selection and extension of the returned word.
    always_comb begin
        shifted = dmem_rdata >> {off_q, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ext     = (f3_q[1:0] == 2'b00) ? {{24{~f3_q[2] & byte_v[7]}}, byte_v} :
                  (f3_q[1:0] == 2'b01) ? {{16{~f3_q[2] & half_v[15]}}, half_v} :
                                         dmem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        done     = 1'b0;
        dmem_req = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept)
                    state_nx = (fault_nx == 2'b00) ? REQ : RESP;
            end
            REQ: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
                if (dmem_ready || timed_out)
                    state_nx = RESP;
            end
            RESP: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_addr  <= '0;
            dmem_we    <= 1'b0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            off_q      <= '0;
            f3_q       <= '0;
            load_q     <= 1'b0;
            fault      <= '0;
            load_data  <= '0;
            cnt        <= '0;
        end else begin
            if (accept)
                fault <= fault_nx;
            if (accept && (fault_nx == 2'b00)) begin
                dmem_addr  <= {alu_result[31:2], 2'b00};
                dmem_we    <= !mem_read;
                dmem_be    <= be_nx;
                dmem_wdata <= wdata_nx;
                off_q      <= alu_result[1:0];
                f3_q       <= funct3;
                load_q     <= mem_read;
            end
            cnt <= (state == REQ) ? cnt + 32'd1 : 32'd0;
            if ((state == REQ) && dmem_ready && load_q)
                load_data <= ext;
            if ((state == REQ) && !dmem_ready && timed_out)
                fault <= 2'b10;
        end
    end
endmodule
